// File: rtl/mesi_snoop_bus_if.sv
// Bus-side signal bundle for the MESI snooping bus arbiter.
// master: the arbiter/sequencer. slave: the caches and the memory port.
interface mesi_snoop_bus_if #(
  parameter int NCACHE = 4,
  parameter int ADDR_W = 32
);
  localparam int IDX_W = $clog2(NCACHE);

  logic [NCACHE-1:0]        req_valid;
  logic [2*NCACHE-1:0]      req_cmd;
  logic [ADDR_W*NCACHE-1:0] req_addr;
  logic [NCACHE-1:0]        grant;
  logic                     bus_valid;
  logic [1:0]               bus_cmd;
  logic [ADDR_W-1:0]        bus_addr;
  logic [IDX_W-1:0]         bus_src;
  logic [NCACHE-1:0]        snoop_hit;
  logic [NCACHE-1:0]        snoop_dirty;
  logic [NCACHE-1:0]        flush_done;
  logic                     mem_req;
  logic                     mem_we;
  logic                     mem_ready;
  logic [NCACHE-1:0]        done;
  logic                     done_shared;
  logic                     err;

  modport master (
    input  req_valid, req_cmd, req_addr, snoop_hit, snoop_dirty, flush_done, mem_ready,
    output grant, bus_valid, bus_cmd, bus_addr, bus_src, mem_req, mem_we, done, done_shared, err
  );

  modport slave (
    output req_valid, req_cmd, req_addr, snoop_hit, snoop_dirty, flush_done, mem_ready,
    input  grant, bus_valid, bus_cmd, bus_addr, bus_src, mem_req, mem_we, done, done_shared, err
  );
endinterface

// File: rtl/mesi_snoop_bus.sv
// Shared snooping bus: round-robin arbitration over cache requests, one broadcast
// transaction at a time, snoop reply collection, dirty-owner writeback sequencing
// and the memory access, ending in a one-hot done pulse with a shared flag.
module mesi_snoop_bus #(
  parameter int NCACHE    = 4,
  parameter int ADDR_W    = 32,
  parameter int SNOOP_LAT = 2
) (
  input logic              clk,
  input logic              rst,
  mesi_snoop_bus_if.master bus
);
  localparam int IDX_W = $clog2(NCACHE);
  localparam int CNT_W = $clog2(SNOOP_LAT + 1);
  // BCAST is the first snoop-window cycle, so SNOOP holds SNOOP_LAT-1 cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SNOOP_LAT >= 2) ? SNOOP_LAT - 2 : 0);
  localparam logic [1:0] CMD_INV = 2'b10;
  localparam logic [1:0] CMD_WB  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_BCAST, S_SNOOP, S_WAITWB, S_MEM, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [NCACHE-1:0]   r_grant;
  logic [IDX_W-1:0]    r_src, r_rr_ptr, r_dirty_idx;
  logic [1:0]          r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_shared, r_err;

  logic                w_found;
  logic [IDX_W-1:0]    w_sel;
  logic [1:0]          w_sel_cmd;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [NCACHE-1:0]   w_hit_m, w_dirty_m;
  logic [IDX_W-1:0]    w_dirty_idx;
  logic                w_any_dirty, w_multi_dirty, w_snoop_go;

  // Round-robin pick: first requester at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NCACHE; k++) begin
      if (!w_found && bus.req_valid[(int'(r_rr_ptr) + k) % NCACHE]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'((int'(r_rr_ptr) + k) % NCACHE);
      end
    end
  end

  assign w_sel_cmd  = bus.req_cmd[int'(w_sel)*2 +: 2];
  assign w_sel_addr = bus.req_addr[int'(w_sel)*ADDR_W +: ADDR_W];

  // The owner never snoops its own transaction.
  assign w_hit_m       = bus.snoop_hit   & ~r_grant;
  assign w_dirty_m     = bus.snoop_dirty & ~r_grant;
  assign w_any_dirty   = |w_dirty_m;
  assign w_multi_dirty = |(w_dirty_m & (w_dirty_m - NCACHE'(1)));
  // With a one-cycle window the snoop is sampled during BCAST itself.
  assign w_snoop_go    = (r_state == S_SNOOP && r_cnt == CNT_LAST) ||
                         (SNOOP_LAT == 1 && r_state == S_BCAST && r_cmd != CMD_WB);

  // Lowest-index dirty holder is the one that gets to flush.
  always_comb begin
    w_dirty_idx = '0;
    for (int k = NCACHE - 1; k >= 0; k--) begin
      if (w_dirty_m[k]) w_dirty_idx = IDX_W'(k);
    end
  end

  // State register; reset aborts any transaction without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and the state-derived strobes.
  always_comb begin
    w_next          = r_state;
    bus.bus_valid   = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.done        = '0;
    bus.done_shared = 1'b0;
    case (r_state)
      S_IDLE:   if (w_found) w_next = S_BCAST;
      S_BCAST: begin
        bus.bus_valid = 1'b1;
        w_next        = (r_cmd == CMD_WB) ? S_MEM : S_SNOOP;
      end
      S_SNOOP:  w_next = S_SNOOP;
      S_WAITWB: if (bus.flush_done[r_dirty_idx]) w_next = (r_cmd == CMD_INV) ? S_DONE : S_MEM;
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (r_cmd == CMD_WB);
        if (bus.mem_ready) w_next = S_DONE;
      end
      S_DONE: begin
        bus.done        = r_grant;
        bus.done_shared = r_shared;
        w_next          = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
    if (w_snoop_go) w_next = w_any_dirty ? S_WAITWB : ((r_cmd == CMD_INV) ? S_DONE : S_MEM);
  end

  // Transaction capture at grant time and round-robin pointer advance at completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant  <= '0;
      r_src    <= '0;
      r_cmd    <= '0;
      r_addr   <= '0;
      r_rr_ptr <= '0;
    end else if (r_state == S_IDLE && w_found) begin
      r_grant <= NCACHE'(1) << w_sel;
      r_src   <= w_sel;
      r_cmd   <= w_sel_cmd;
      r_addr  <= w_sel_addr;
    end else if (r_state == S_DONE) begin
      r_grant  <= '0;
      r_rr_ptr <= (r_src == IDX_W'(NCACHE - 1)) ? '0 : r_src + IDX_W'(1);
    end
  end

  // Snoop window counter and latched snoop results; err is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_shared    <= 1'b0;
      r_dirty_idx <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_cnt    <= '0;
        r_shared <= 1'b0;
      end else if (r_state == S_SNOOP) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_snoop_go) begin
        r_shared    <= |w_hit_m;
        r_dirty_idx <= w_dirty_idx;
        if (w_multi_dirty) r_err <= 1'b1;
      end
    end
  end

  assign bus.grant    = r_grant;
  assign bus.bus_src  = r_src;
  assign bus.bus_cmd  = r_cmd;
  assign bus.bus_addr = r_addr;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_mesi_snoop_bus.sv
// Directed bench for mesi_snoop_bus (NCACHE=4, ADDR_W=32, SNOOP_LAT=2).
module tb_mesi_snoop_bus;
  localparam int NC  = 4;
  localparam int AW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   mem_lat  = 0;
  int   mem_wait = 0;
  int   bv_cnt = 0, mr_cnt = 0, mw_cnt = 0, dn_cnt = 0;

  mesi_snoop_bus_if #(.NCACHE(NC), .ADDR_W(AW)) ifc ();

  mesi_snoop_bus #(.NCACHE(NC), .ADDR_W(AW), .SNOOP_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Memory model: raises mem_ready after mem_lat cycles of mem_req.
  always @(posedge clk) begin
    #2;
    if (ifc.mem_req === 1'b1) begin
      ifc.mem_ready = (mem_wait >= mem_lat);
      mem_wait++;
    end else begin
      ifc.mem_ready = 1'b0;
      mem_wait = 0;
    end
  end

  // Activity counters sampled mid-cycle.
  always @(negedge clk) begin
    if (ifc.bus_valid === 1'b1) bv_cnt++;
    if (ifc.mem_req === 1'b1) mr_cnt++;
    if (ifc.mem_req === 1'b1 && ifc.mem_we === 1'b1) mw_cnt++;
    if (ifc.done !== '0) dn_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic [1:0] cmd, input logic [31:0] addr);
    ifc.req_cmd[c*2 +: 2]   = cmd;
    ifc.req_addr[c*AW +: AW] = addr;
    ifc.req_valid[c]         = 1'b1;
  endtask

  task automatic wait_done(input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      tick();
      if (ifc.done !== '0) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic wait_grant(input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      tick();
      if (ifc.grant !== '0) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic clear_inputs();
    ifc.req_valid   = '0;
    ifc.snoop_hit   = '0;
    ifc.snoop_dirty = '0;
    ifc.flush_done  = '0;
  endtask

  task automatic test_reset();
    ifc.req_cmd  = '0;
    ifc.req_addr = '0;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk_cnt++; if (ifc.grant !== 4'b0000) $display("FAIL rst_grant got=%b exp=0000", ifc.grant); else pass_cnt++;
    chk_cnt++; if (ifc.bus_valid !== 1'b0) $display("FAIL rst_bus_valid got=%b exp=0", ifc.bus_valid); else pass_cnt++;
    chk_cnt++; if (ifc.mem_req !== 1'b0) $display("FAIL rst_mem_req got=%b exp=0", ifc.mem_req); else pass_cnt++;
    chk_cnt++; if (ifc.done !== 4'b0000) $display("FAIL rst_done got=%b exp=0000", ifc.done); else pass_cnt++;
    chk_cnt++; if (ifc.err !== 1'b0) $display("FAIL rst_err got=%b exp=0", ifc.err); else pass_cnt++;
    chk_cnt++; if ({ifc.bus_cmd, ifc.bus_addr, ifc.bus_src, ifc.done_shared, ifc.mem_we} !== '0)
      $display("FAIL rst_bus_fields got=%h/%h/%h/%b/%b exp=0", ifc.bus_cmd, ifc.bus_addr, ifc.bus_src, ifc.done_shared, ifc.mem_we); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    int n, m;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    mem_lat = 0;
    for (int c = 0; c < NC; c++) set_req(c, 2'b00, 32'h100 * (c + 1));
    for (int i = 0; i < 5; i++) begin
      wait_grant(10, n);
      chk_cnt++; if (n !== ((i == 0) ? 1 : 2)) $display("FAIL rr_gap%0d got=%0d exp=%0d", i, n, (i == 0) ? 1 : 2); else pass_cnt++;
      chk_cnt++; if (ifc.grant !== exp_g[i]) $display("FAIL rr_grant%0d got=%b exp=%b", i, ifc.grant, exp_g[i]); else pass_cnt++;
      wait_done(10, m);
      chk_cnt++; if (ifc.done !== exp_g[i]) $display("FAIL rr_done%0d got=%b exp=%b", i, ifc.done, exp_g[i]); else pass_cnt++;
      if (i != 0) ifc.req_valid = ifc.req_valid & ~exp_g[i];
    end
    tick();
  endtask

  task automatic test_single_read();
    int n, bv0, mr0, mw0;
    bv0 = bv_cnt; mr0 = mr_cnt; mw0 = mw_cnt;
    mem_lat = 1;
    set_req(1, 2'b00, 32'h40);
    tick();
    chk_cnt++; if (ifc.grant !== 4'b0010) $display("FAIL t1_grant got=%b exp=0010", ifc.grant); else pass_cnt++;
    chk_cnt++; if (ifc.bus_src !== 2'd1 || ifc.bus_addr !== 32'h40 || ifc.bus_cmd !== 2'b00)
      $display("FAIL t1_bus got=src%0d addr%h cmd%b exp=src1 addr40 cmd00", ifc.bus_src, ifc.bus_addr, ifc.bus_cmd); else pass_cnt++;
    wait_done(20, n);
    chk_cnt++; if (n !== 4) $display("FAIL t1_latency got=%0d exp=4", n); else pass_cnt++;
    chk_cnt++; if (ifc.done !== 4'b0010) $display("FAIL t1_done got=%b exp=0010", ifc.done); else pass_cnt++;
    chk_cnt++; if (ifc.done_shared !== 1'b0) $display("FAIL t1_shared got=%b exp=0", ifc.done_shared); else pass_cnt++;
    ifc.req_valid = '0;
    tick();
    chk_cnt++; if (ifc.grant !== 4'b0000) $display("FAIL t1_grant_drop got=%b exp=0000", ifc.grant); else pass_cnt++;
    chk_cnt++; if (bv_cnt - bv0 !== 1) $display("FAIL t1_bus_valid_count got=%0d exp=1", bv_cnt - bv0); else pass_cnt++;
    chk_cnt++; if (mr_cnt - mr0 !== 2 || mw_cnt - mw0 !== 0)
      $display("FAIL t1_mem got=req%0d we%0d exp=req2 we0", mr_cnt - mr0, mw_cnt - mw0); else pass_cnt++;
  endtask

  task automatic test_min_latency();
    int n;
    mem_lat = 0;
    ifc.snoop_hit   = 4'b1000;
    ifc.snoop_dirty = 4'b1000;
    set_req(3, 2'b00, 32'h3C0);
    wait_done(20, n);
    chk_cnt++; if (n !== 2 + LAT) $display("FAIL min_latency got=%0d exp=%0d", n, 2 + LAT); else pass_cnt++;
    chk_cnt++; if (ifc.done !== 4'b1000 || ifc.done_shared !== 1'b0)
      $display("FAIL own_mask got=done%b sh%b exp=done1000 sh0", ifc.done, ifc.done_shared); else pass_cnt++;
    clear_inputs();
    tick();
    chk_cnt++; if (ifc.err !== 1'b0) $display("FAIL own_mask_err got=%b exp=0", ifc.err); else pass_cnt++;
  endtask

  task automatic test_dirty_writeback();
    int n;
    mem_lat = 0;
    ifc.snoop_hit   = 4'b0100;
    ifc.snoop_dirty = 4'b0100;
    set_req(0, 2'b01, 32'h200);
    tick(); tick(); tick();
    ifc.flush_done = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      chk_cnt++; if (ifc.mem_req !== 1'b0 || ifc.done !== 4'b0000)
        $display("FAIL t3_waitwb%0d got=req%b done%b exp=req0 done0000", k, ifc.mem_req, ifc.done); else pass_cnt++;
      tick();
    end
    ifc.flush_done = 4'b0100;
    tick();
    ifc.flush_done = 4'b0000;
    chk_cnt++; if (ifc.mem_req !== 1'b1 || ifc.mem_we !== 1'b0)
      $display("FAIL t3_mem got=req%b we%b exp=req1 we0", ifc.mem_req, ifc.mem_we); else pass_cnt++;
    wait_done(10, n);
    chk_cnt++; if (n !== 1) $display("FAIL t3_latency got=%0d exp=1", n); else pass_cnt++;
    chk_cnt++; if (ifc.done !== 4'b0001 || ifc.done_shared !== 1'b1)
      $display("FAIL t3_done got=done%b sh%b exp=done0001 sh1", ifc.done, ifc.done_shared); else pass_cnt++;
    chk_cnt++; if (ifc.err !== 1'b0) $display("FAIL t3_err got=%b exp=0", ifc.err); else pass_cnt++;
    clear_inputs();
    tick();
  endtask

  task automatic test_inv_upgrade();
    int n, mr0;
    mr0 = mr_cnt;
    mem_lat = 0;
    ifc.snoop_hit = 4'b1010;
    set_req(3, 2'b10, 32'h300);
    wait_done(20, n);
    chk_cnt++; if (n < 1 + LAT || n > 2 + LAT) $display("FAIL t4_latency got=%0d exp=%0d..%0d", n, 1 + LAT, 2 + LAT); else pass_cnt++;
    chk_cnt++; if (ifc.done !== 4'b1000 || ifc.done_shared !== 1'b1)
      $display("FAIL t4_done got=done%b sh%b exp=done1000 sh1", ifc.done, ifc.done_shared); else pass_cnt++;
    clear_inputs();
    tick();
    chk_cnt++; if (ifc.done_shared !== 1'b0 || ifc.done !== 4'b0000)
      $display("FAIL t4_after_done got=done%b sh%b exp=done0000 sh0", ifc.done, ifc.done_shared); else pass_cnt++;
    chk_cnt++; if (mr_cnt - mr0 !== 0) $display("FAIL t4_no_mem got=%0d exp=0", mr_cnt - mr0); else pass_cnt++;
  endtask

  task automatic test_writeback();
    int n, bv0, mw0;
    bv0 = bv_cnt; mw0 = mw_cnt;
    mem_lat = 2;
    ifc.snoop_hit   = 4'b0011;
    ifc.snoop_dirty = 4'b0011;
    set_req(2, 2'b11, 32'h80);
    tick();
    tick();
    chk_cnt++; if (ifc.mem_req !== 1'b1 || ifc.mem_we !== 1'b1)
      $display("FAIL t5_mem got=req%b we%b exp=req1 we1", ifc.mem_req, ifc.mem_we); else pass_cnt++;
    chk_cnt++; if (ifc.bus_cmd !== 2'b11 || ifc.bus_addr !== 32'h80)
      $display("FAIL t5_bus got=cmd%b addr%h exp=cmd11 addr80", ifc.bus_cmd, ifc.bus_addr); else pass_cnt++;
    wait_done(20, n);
    chk_cnt++; if (n !== 3) $display("FAIL t5_latency got=%0d exp=3", n); else pass_cnt++;
    chk_cnt++; if (ifc.done !== 4'b0100 || ifc.done_shared !== 1'b0)
      $display("FAIL t5_done got=done%b sh%b exp=done0100 sh0", ifc.done, ifc.done_shared); else pass_cnt++;
    clear_inputs();
    tick();
    chk_cnt++; if (mw_cnt - mw0 !== 3 || bv_cnt - bv0 !== 1)
      $display("FAIL t5_counts got=we%0d bv%0d exp=we3 bv1", mw_cnt - mw0, bv_cnt - bv0); else pass_cnt++;
    chk_cnt++; if (ifc.err !== 1'b0) $display("FAIL t5_err got=%b exp=0", ifc.err); else pass_cnt++;
  endtask

  task automatic test_multi_dirty();
    int n;
    mem_lat = 0;
    ifc.snoop_hit   = 4'b1100;
    ifc.snoop_dirty = 4'b1100;
    set_req(1, 2'b00, 32'h400);
    tick(); tick(); tick();
    chk_cnt++; if (ifc.err !== 1'b1 || ifc.mem_req !== 1'b0)
      $display("FAIL t6_err_set got=err%b req%b exp=err1 req0", ifc.err, ifc.mem_req); else pass_cnt++;
    ifc.flush_done = 4'b1000;
    tick();
    chk_cnt++; if (ifc.mem_req !== 1'b0) $display("FAIL t6_lowest_idx got=%b exp=0", ifc.mem_req); else pass_cnt++;
    ifc.flush_done = 4'b0100;
    tick();
    ifc.flush_done = 4'b0000;
    chk_cnt++; if (ifc.mem_req !== 1'b1) $display("FAIL t6_mem got=%b exp=1", ifc.mem_req); else pass_cnt++;
    wait_done(10, n);
    chk_cnt++; if (ifc.done !== 4'b0010 || ifc.done_shared !== 1'b1)
      $display("FAIL t6_done got=done%b sh%b exp=done0010 sh1", ifc.done, ifc.done_shared); else pass_cnt++;
    clear_inputs();
    tick(); tick(); tick();
    chk_cnt++; if (ifc.err !== 1'b1) $display("FAIL t6_err_sticky got=%b exp=1", ifc.err); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n, dn0;
    bit seen;
    mem_lat = 50;
    seen = 1'b0;
    set_req(0, 2'b00, 32'h500);
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (ifc.mem_req === 1'b1) seen = 1'b1;
    end
    chk_cnt++; if (seen !== 1'b1) $display("FAIL t7_reach_mem got=%b exp=1", seen); else pass_cnt++;
    dn0 = dn_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk_cnt++; if (ifc.mem_req !== 1'b0 || ifc.grant !== 4'b0000 || ifc.bus_addr !== 32'h0)
      $display("FAIL t7_async_clear got=req%b grant%b addr%h exp=0", ifc.mem_req, ifc.grant, ifc.bus_addr); else pass_cnt++;
    chk_cnt++; if (ifc.err !== 1'b0) $display("FAIL t7_err_clear got=%b exp=0", ifc.err); else pass_cnt++;
    clear_inputs();
    tick(); tick();
    rst = 1'b0;
    mem_lat = 0;
    tick();
    chk_cnt++; if (dn_cnt - dn0 !== 0) $display("FAIL t7_no_done got=%0d exp=0", dn_cnt - dn0); else pass_cnt++;
    set_req(1, 2'b00, 32'h600);
    set_req(2, 2'b00, 32'h700);
    tick();
    chk_cnt++; if (ifc.grant !== 4'b0010) $display("FAIL t7_rr_reset got=%b exp=0010", ifc.grant); else pass_cnt++;
    wait_done(10, n);
    chk_cnt++; if (n !== 3 || ifc.done !== 4'b0010) $display("FAIL t7_post_reset got=n%0d done%b exp=n3 done0010", n, ifc.done); else pass_cnt++;
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_min_latency();
    test_dirty_writeback();
    test_inv_upgrade();
    test_writeback();
    test_multi_dirty();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
